// File: rtl/timer.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT registers in a 16-byte window,
// one-shot or auto-reload counting, masked interrupt from a registered flag.
module timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CNT  = 2'd1;
  localparam logic [1:0] ST_INT  = 2'd2;

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [1:0]  state;
  logic        flag;

  logic        sel;
  logic [1:0]  off;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic        auto_reload;
  logic        unused_addr_bits;

  assign sel         = (addr[31:4] == BASE_ADDR[31:4]);
  assign off         = addr[3:2];
  assign wr_ctrl     = sel & write_enable & (off == 2'd0);
  assign wr_preset   = sel & write_enable & (off == 2'd1);
  assign en          = ctrl[0];
  // Only MODE==1 reloads; 0, 2 and 3 are all one-shot.
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign unused_addr_bits = ^addr[1:0];

  always_comb begin
    read_result = '0;
    if (sel) begin
      case (off)
        2'd0:    read_result = {28'd0, ctrl};
        2'd1:    read_result = preset;
        2'd2:    read_result = count;
        default: read_result = '0;
      endcase
    end
  end

  assign irq       = flag & ctrl[3];
  assign dbg_state = state;

  // Bus writes are applied first; FSM assignments below override them where
  // they collide, so a flag set beats a write-clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      state  <= ST_IDLE;
      flag   <= 1'b0;
    end else begin
      if (wr_ctrl)   ctrl   <= write_data[3:0];
      if (wr_preset) preset <= write_data;
      if (wr_ctrl || wr_preset) flag <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (en) begin
            count <= preset;
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= '0;
            flag  <= 1'b1;
            state <= ST_INT;
          end
        end
        ST_INT: begin
          if (auto_reload) begin
            count <= preset;
            flag  <= 1'b0;
            state <= ST_CNT;
          end else begin
            // A CTRL write in this cycle keeps its EN value.
            if (!wr_ctrl) ctrl[0] <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_timer.sv
// Directed bench for the countdown timer: register access, one-shot, auto-reload,
// masking/pause, address decode, simultaneous events and asynchronous reset.
module tb_timer;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic        irq;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  logic [31:0] exp_q[$];
  logic [31:0] exp_irq_q[$];

  timer #(.BASE_ADDR(32'h0000_7F00)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_result  (read_result),
    .irq          (irq),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called 1ns after a rising edge; returns 1ns after the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr         = a;
    write_data   = d;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    write_data   = '0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, read_result, exp);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b0;
    addr         = '0;
    write_enable = 1'b0;
    write_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // reset state
    rd_check("rst_ctrl", A_CTRL, 32'h0);
    rd_check("rst_preset", A_PRESET, 32'h0);
    rd_check("rst_count", A_COUNT, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // one-shot, PRESET=3: COUNT 3,2,1,0 after k+1..k+4, irq from k+4
    bus_write(A_PRESET, 32'd3);
    bus_write(A_CTRL, 32'h9);
    exp_q = {32'd3, 32'd2, 32'd1, 32'd0};
    exp_irq_q = {32'd0, 32'd0, 32'd0, 32'd1};
    while (exp_q.size() > 0) begin
      tick();
      rd_check("os_count", A_COUNT, exp_q.pop_front());
      check("os_irq", {31'd0, irq}, exp_irq_q.pop_front());
    end
    tick();
    check("os_irq_hold1", {31'd0, irq}, 32'd1);
    rd_check("os_ctrl_en_clr", A_CTRL, 32'h8);
    check("os_idle", {30'd0, dbg_state}, 32'd0);
    tick();
    check("os_irq_hold2", {31'd0, irq}, 32'd1);
    bus_write(A_PRESET, 32'd3);
    check("os_irq_clr", {31'd0, irq}, 32'd0);

    // one-shot, PRESET=0: irq after k+2
    bus_write(A_PRESET, 32'd0);
    bus_write(A_CTRL, 32'h9);
    tick();
    rd_check("p0_count", A_COUNT, 32'd0);
    check("p0_irq_k1", {31'd0, irq}, 32'd0);
    tick();
    check("p0_irq_k2", {31'd0, irq}, 32'd1);
    bus_write(A_CTRL, 32'h0);
    check("p0_irq_clr", {31'd0, irq}, 32'd0);
    rd_check("p0_ctrl", A_CTRL, 32'h0);

    // flag set and PRESET write in the same cycle: set wins
    bus_write(A_PRESET, 32'd1);
    bus_write(A_CTRL, 32'h9);
    tick();
    bus_write(A_PRESET, 32'd7);
    check("sim_set_wins", {31'd0, irq}, 32'd1);
    // CTRL write during the mode-0 INT cycle keeps EN and reloads next edge
    bus_write(A_CTRL, 32'h9);
    rd_check("sim_ctrl_kept", A_CTRL, 32'h9);
    check("sim_irq_clr", {31'd0, irq}, 32'd0);
    tick();
    rd_check("sim_reload", A_COUNT, 32'd7);
    check("sim_cnt_state", {30'd0, dbg_state}, 32'd1);
    bus_write(A_CTRL, 32'h0);
    tick();
    rd_check("sim_frozen", A_COUNT, 32'd6);

    // auto-reload, PRESET=2: period 3, one-cycle pulses
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'hB);
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(32'd2 - 32'(i % 3));
      exp_irq_q.push_back((i % 3 == 2) ? 32'd1 : 32'd0);
    end
    while (exp_q.size() > 0) begin
      tick();
      rd_check("ar_count", A_COUNT, exp_q.pop_front());
      check("ar_irq", {31'd0, irq}, exp_irq_q.pop_front());
    end
    bus_write(A_CTRL, 32'h0);
    tick();
    check("ar_stop_irq", {31'd0, irq}, 32'd0);

    // masked: internal cycle completes, irq stays low
    bus_write(A_PRESET, 32'd2);
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("mask_irq", {31'd0, irq}, 32'd0);
    end
    rd_check("mask_ctrl_en_clr", A_CTRL, 32'h0);

    // pause: two counts then clear EN, COUNT frozen at 3
    bus_write(A_PRESET, 32'd5);
    bus_write(A_CTRL, 32'h9);
    tick();
    tick();
    bus_write(A_CTRL, 32'h8);
    tick();
    tick();
    rd_check("pause_count", A_COUNT, 32'd3);
    check("pause_irq", {31'd0, irq}, 32'd0);
    check("pause_idle", {30'd0, dbg_state}, 32'd0);

    // address decode
    rd_check("dec_out_lo", 32'h0000_7E04, 32'h0);
    rd_check("dec_out_hi", 32'h8000_7F04, 32'h0);
    rd_check("dec_byte_ign", 32'h0000_7F07, 32'd5);
    bus_write(A_COUNT, 32'h55);
    rd_check("dec_count_ro", A_COUNT, 32'd3);
    bus_write(A_RSVD, 32'h1234);
    rd_check("dec_rsvd", A_RSVD, 32'h0);
    bus_write(32'h0000_7E00, 32'h9);
    rd_check("dec_wr_outside", A_CTRL, 32'h8);
    bus_write(A_CTRL, 32'hFFFF_FFF0);
    rd_check("dec_ctrl_upper", A_CTRL, 32'h0);

    // asynchronous reset while irq is high
    bus_write(A_PRESET, 32'd1);
    bus_write(A_CTRL, 32'h9);
    tick();
    tick();
    check("ar_pre_irq", {31'd0, irq}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("async_irq", {31'd0, irq}, 32'd0);
    addr = A_PRESET;
    #0.5;
    check("async_preset", read_result, 32'h0);
    addr = A_CTRL;
    #0.5;
    check("async_ctrl", read_result, 32'h0);
    tick();
    #2;
    rst = 1'b1;
    tick();
    tick();
    rd_check("post_rst_count", A_COUNT, 32'h0);
    check("post_rst_idle", {30'd0, dbg_state}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer.md
# timer

Memory-mapped countdown timer that answers the CPU's system-bus accesses (address, write enable, write data, combinational read data) as a bus responder and raises one of the CPU's `hwirq` lines. It sits behind the bridge, which drives this block's bus inputs from `cpu_addr`, `dev_write_enable` and `cpu_write_data`. The bridge returns `read_result` to the CPU in the same M-stage cycle. Two counting modes are supported: one-shot and auto-reload.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00: byte base address of the 16-byte register window. Bits [3:0] are ignored.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset. Low immediately forces the reset state.
- `addr` input 32: byte address from the bus.
- `write_enable` input 1: write strobe, qualified by the address select.
- `write_data` input 32: write data.
- `read_result` output 32: read data. Combinational from `addr` and the registers.
- `irq` output 1: interrupt request to `hwirq`.

## Operation
- Select: `sel = (addr[31:4] == BASE_ADDR[31:4])`. The register offset is `addr[3:2]`. `addr[1:0]` is ignored.
- Registers:
  - Offset 0, CTRL, R/W. Only bits [3:0] are stored: [0] EN, [2:1] MODE, [3] IM. Bits [31:4] read 0.
  - Offset 1, PRESET, R/W, 32 bits.
  - Offset 2, COUNT, read-only. Writes to it are ignored.
  - Offset 3 reads 0. Writes to it are ignored.
- `read_result` is 0 when `sel` is 0.
- MODE: 0 is one-shot, 1 is auto-reload. MODE values 2 and 3 behave exactly as mode 0.
- FSM states: IDLE, CNT, INT. Register updates happen at the clock edge.
  - IDLE: if EN=1, load COUNT<=PRESET and go to CNT. Otherwise hold.
  - CNT: if EN=0, go to IDLE and hold COUNT. Else if COUNT>1, COUNT<=COUNT-1. Else (COUNT is 0 or 1): COUNT<=0, flag<=1, go to INT.
  - INT, mode 0: EN<=0, go to IDLE. The flag stays set.
  - INT, mode 1: COUNT<=PRESET, flag<=0, go to CNT.
- Output: `irq = flag & IM`. The output is registered-flag based and glitch-free.
- Flag clearing:
  - In mode 0, the flag is cleared by any bus write to CTRL or PRESET.
  - In mode 1, the flag is high only during the INT cycle.
- Simultaneous events:
  - A bus write to CTRL in the INT cycle takes priority over the FSM's EN clear. The written EN is kept.
  - A write to CTRL or PRESET in the same cycle the flag is being set leaves the flag at 1, because the set wins.
- Writing PRESET during CNT does not change COUNT. The new value is used at the next load.
- Clearing EN during CNT stops counting. COUNT is frozen and readable.
- Setting EN again from IDLE reloads COUNT from PRESET. Counting does not resume from the frozen value.
- Arithmetic: the decrement is unsigned 32-bit. COUNT never wraps below 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, flag=0, `irq`=0. `read_result` is 0 for any CTRL/PRESET/COUNT read until the first write.
- A bus write that enables the timer lands at edge k.
  - Edge k+1: COUNT=PRESET.
  - Edges k+2 through k+N: COUNT decrements to 1.
  - Edge k+N+1: INT state, `irq` rises if IM=1.
- One-shot: PRESET=N≥1 puts `irq` high after edge k+N+1. PRESET=0 raises `irq` after edge k+2.
- Auto-reload period: N+1 cycles. `irq` is high for exactly 1 cycle per period.
- Reads have zero latency, combinational in the same cycle.
- Writes are visible to reads from the following cycle.
- Reset asserted mid-count clears everything asynchronously. `irq` drops at once, without waiting for `clk`.

## Test plan
- Reset: drive `rst`=0 during counting. Required: `irq`=0 and CTRL/PRESET/COUNT read 0 asynchronously. After release, the block stays in IDLE.
- One-shot: write PRESET=3, then write CTRL=0x9 at edge k. Required:
  - COUNT reads 3, 2, 1, 0 after edges k+1 through k+4.
  - `irq`=1 from edge k+4 and held.
  - CTRL reads 0x8.
  - Writing PRESET drops `irq` the next cycle.
- Auto-reload: PRESET=2, CTRL=0xB. Required: `irq` one-cycle pulses every 3 cycles. COUNT cycles through 2, 1, 0.
- Mask and pause: CTRL=0x1 with PRESET=2. Required: `irq` stays 0 while the internal cycle completes. Then set PRESET=5, CTRL=0x9, and after 2 counts write CTRL=0x8. Required: COUNT frozen at 3 and `irq`=0.
- Address decode: reads outside the window return 0. A write to COUNT (offset 8) with data 0x55 leaves COUNT unchanged. Offset 0xC reads 0. CTRL upper bits written with 0xFFFFFFF0 read back 0.
- Simultaneous events: write CTRL=0x9 in the mode-0 INT cycle. Required: EN stays 1 and the timer reloads from PRESET at the next edge.
